// File: rtl/battle_pkg.sv
// battle_pkg: shared encodings for the battle-screen controller.
//   Key codes, page codes, player opcodes, movement directions,
//   state-field widths and helpers to build MOV instructions.
package battle_pkg;

    localparam int PAGE_W = 4;
    localparam int SUB_W  = 4;

    typedef enum logic [3:0] {
        KEY_IDLE  = 4'd0,
        KEY_W     = 4'd1,
        KEY_D     = 4'd2,
        KEY_S     = 4'd3,
        KEY_A     = 4'd4,
        KEY_J     = 4'd5,
        KEY_K     = 4'd6,
        KEY_L     = 4'd7,
        KEY_SPACE = 4'd8
    } key_e;

    typedef enum logic [PAGE_W-1:0] {
        PG_MENU   = 4'd1,
        PG_DODGE  = 4'd9,
        PG_ATTACK = 4'd10,
        PG_ACTION = 4'd11,
        PG_OVER   = 4'd12
    } page_e;

    typedef enum logic [3:0] {
        OP_HPY = 4'd1,
        OP_DPY = 4'd2,
        OP_IDG = 4'd3,
        OP_SDG = 4'd4,
        OP_MOV = 4'd5,
        OP_SHP = 4'd6
    } opcode_e;

    typedef enum logic [7:0] {
        DIR_UP    = 8'd0,
        DIR_RIGHT = 8'd1,
        DIR_DOWN  = 8'd2,
        DIR_LEFT  = 8'd3
    } dir_e;

    function automatic logic is_dir_key(input logic [3:0] key);
        return (key == KEY_W) || (key == KEY_D) || (key == KEY_S) || (key == KEY_A);
    endfunction

    // Caller guarantees key is one of W/D/S/A.
    function automatic logic [15:0] mov_instr(input logic [3:0] key);
        dir_e dir;
        case (key)
            KEY_W:   dir = DIR_UP;
            KEY_D:   dir = DIR_RIGHT;
            KEY_S:   dir = DIR_DOWN;
            default: dir = DIR_LEFT;
        endcase
        return {OP_MOV, dir, 4'b0000};
    endfunction

endpackage

// File: rtl/battle_fsm_key_edge.sv
// key_edge: press detector for the keyboard code.
//   clk, rst      clock, async active-high reset
//   keyboard      current key code
//   press         keyboard is non-idle and differs from last cycle's code
//   press_key     keyboard when press is set, otherwise 0
module key_edge
    import battle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keyboard,
    output logic       press,
    output logic [3:0] press_key
);

    logic [3:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 4'd0;
        else     prev_q <= keyboard;
    end

    // prev_q tracks the key in every page, so a key held across a page
    // change never looks like a fresh press afterwards.
    assign press     = (keyboard != KEY_IDLE) && (keyboard != prev_q);
    assign press_key = press ? keyboard : 4'd0;

endmodule

// File: rtl/battle_fsm.sv
// battle_fsm: battle-screen game-flow controller.
//   clk, rst      clock, async active-high reset
//   keyboard      key code (0 idle, W D S A J K L SPACE = 1..8)
//   is_death      player depleted during a dodge turn
//   atk_pass      one-cycle strobe, attack bar resolved; dmg_mon valid with it
//   state         {page, substage}
//   player_instr  {opcode, dir, 4'b0}; MOV only while dodging
//   is_move       player_instr carries a MOV
//   mon_dmg       saturating accumulated monster damage
//   turn_left     remaining dodge clocks, 0 outside DODGE
//
// state     | meaning
// MENU   1  | title page, SPACE starts a fresh battle
// DODGE  9  | timed dodge turn, W/D/S/A steer the player
// ATTACK 10 | waiting for the attack bar, bounded by a timeout
// ACTION 11 | action menu, substage is the cursor
// OVER   12 | result page, substage 0 lose / 1 win
module battle_fsm
    import battle_pkg::*;
#(
    parameter int HP_W         = 8,
    parameter int MON_HP_MAX   = 100,
    parameter int DODGE_CYCLES = 600,
    parameter int ATK_TIMEOUT  = 300,
    parameter int N_ACTIONS    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        keyboard,
    input  logic                              is_death,
    input  logic                              atk_pass,
    input  logic [HP_W-1:0]                   dmg_mon,
    output logic [7:0]                        state,
    output logic [15:0]                       player_instr,
    output logic                              is_move,
    output logic [HP_W-1:0]                   mon_dmg,
    output logic [$clog2(DODGE_CYCLES+1)-1:0] turn_left
);

    localparam int TL_W = $clog2(DODGE_CYCLES+1);
    localparam int TO_W = $clog2(ATK_TIMEOUT+1);
    localparam logic [TL_W-1:0]  TURN_LOAD = TL_W'(DODGE_CYCLES);
    localparam logic [TO_W-1:0]  TMO_LOAD  = TO_W'(ATK_TIMEOUT);
    localparam logic [SUB_W-1:0] CUR_LAST  = SUB_W'(N_ACTIONS - 1);

    page_e             page_q, page_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [15:0]       instr_q, instr_d;
    logic              move_q, move_d;
    logic [HP_W-1:0]   dmg_q, dmg_d;
    logic [TL_W-1:0]   turn_q, turn_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic              press;
    logic [3:0]        press_key;
    logic [HP_W:0]     dmg_sum;
    logic [HP_W-1:0]   dmg_sat;

    key_edge u_key_edge (
        .clk       (clk),
        .rst       (rst),
        .keyboard  (keyboard),
        .press     (press),
        .press_key (press_key)
    );

    // One extra bit catches the carry so the accumulator clamps at all-ones.
    assign dmg_sum = {1'b0, dmg_q} + {1'b0, dmg_mon};
    assign dmg_sat = dmg_sum[HP_W] ? {HP_W{1'b1}} : dmg_sum[HP_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_q  <= PG_MENU;
            sub_q   <= '0;
            instr_q <= '0;
            move_q  <= 1'b0;
            dmg_q   <= '0;
            turn_q  <= '0;
            tmo_q   <= '0;
        end else begin
            page_q  <= page_d;
            sub_q   <= sub_d;
            instr_q <= instr_d;
            move_q  <= move_d;
            dmg_q   <= dmg_d;
            turn_q  <= turn_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        page_d  = page_q;
        sub_d   = sub_q;
        instr_d = '0;
        move_d  = 1'b0;
        dmg_d   = dmg_q;
        turn_d  = '0;
        tmo_d   = tmo_q;
        case (page_q)
            PG_MENU: begin
                sub_d = '0;
                if (press && press_key == KEY_SPACE) begin
                    page_d = PG_DODGE;
                    dmg_d  = '0;
                    turn_d = TURN_LOAD;
                end
            end
            PG_DODGE: begin
                sub_d = '0;
                if (is_death) begin
                    page_d = PG_OVER;
                end else if (turn_q <= TL_W'(1)) begin
                    page_d = PG_ACTION;
                end else begin
                    turn_d = turn_q - TL_W'(1);
                    // Movement follows the held key, not press events.
                    if (is_dir_key(keyboard)) begin
                        move_d  = 1'b1;
                        instr_d = mov_instr(keyboard);
                    end
                end
            end
            PG_ACTION: begin
                if (press) begin
                    case (press_key)
                        KEY_D: sub_d = (sub_q >= CUR_LAST) ? '0 : sub_q + SUB_W'(1);
                        KEY_A: sub_d = (sub_q == '0) ? CUR_LAST : sub_q - SUB_W'(1);
                        KEY_J: begin
                            sub_d = '0;
                            if (sub_q == '0) begin
                                page_d = PG_ATTACK;
                                tmo_d  = TMO_LOAD;
                            end else begin
                                page_d = PG_DODGE;
                                turn_d = TURN_LOAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            PG_ATTACK: begin
                sub_d = '0;
                // A resolve on the timeout clock still counts.
                if (atk_pass) begin
                    dmg_d = dmg_sat;
                    tmo_d = '0;
                    if (32'(dmg_sat) > MON_HP_MAX) begin
                        page_d = PG_OVER;
                        sub_d  = SUB_W'(1);
                    end else begin
                        page_d = PG_DODGE;
                        turn_d = TURN_LOAD;
                    end
                end else if (tmo_q <= TO_W'(1)) begin
                    tmo_d  = '0;
                    page_d = PG_DODGE;
                    turn_d = TURN_LOAD;
                end else begin
                    tmo_d = tmo_q - TO_W'(1);
                end
            end
            PG_OVER: begin
                if (press && press_key == KEY_SPACE) begin
                    page_d = PG_MENU;
                    sub_d  = '0;
                end
            end
            default: begin
                page_d = PG_MENU;
                sub_d  = '0;
            end
        endcase
    end

    assign state        = {page_q, sub_q};
    assign player_instr = instr_q;
    assign is_move      = move_q;
    assign mon_dmg      = dmg_q;
    assign turn_left    = turn_q;

endmodule

// File: doc/battle_fsm.md
# battle_fsm

Parametrised top-level game-flow controller for the battle screen. It sequences MENU → DODGE → ACTION → ATTACK → GAME-OVER pages and translates keyboard codes into player movement instructions. It accumulates damage dealt to the monster, with saturation. It adds timed dodge turns, a wrap-around action cursor, an attack timeout, press-edge key detection and an explicit win/lose page.

## Interface
Parameters:
- HP_W, 8, width of damage input and monster damage accumulator
- MON_HP_MAX, 100, monster is defeated when the accumulator is strictly greater than this
- DODGE_CYCLES, 600, length of one dodge turn in clocks (≥1)
- ATK_TIMEOUT, 300, clocks ATTACK waits for `atk_pass` before aborting (≥1)
- N_ACTIONS, 4, number of ACTION menu entries (2..16)

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  async active-high reset
- keyboard  in  4  current key code: 0 idle, W=1, D=2, S=3, A=4, J=5, K=6, L=7, SPACE=8
- is_death  in  1  player hit-point depletion from dodge engine
- atk_pass  in  1  one-cycle strobe: attack bar resolved
- dmg_mon  in  HP_W  damage of resolved attack, valid with `atk_pass`
- state  out  8  {page[3:0], substage[3:0]}
- player_instr  out  16  {opcode[3:0], dir[7:0], 4'b0}
- is_move  out  1  player_instr carries a MOV this cycle
- mon_dmg  out  HP_W  accumulated monster damage
- turn_left  out  $clog2(DODGE_CYCLES+1)  remaining dodge clocks; 0 outside DODGE

## Operation
- Pages: MENU=1, DODGE=9, ATTACK=10, ACTION=11, OVER=12. Any other page → next clock {MENU,0}.
- Substage: 0 in MENU, DODGE and ATTACK; cursor index in ACTION; 0 = lose, 1 = win in OVER.
- Press event: keyboard ≠ 0 and keyboard ≠ previous-cycle keyboard. Only DODGE movement is level-sensitive.
- MENU: SPACE press → DODGE. Clear mon_dmg; load turn_left = DODGE_CYCLES.
- DODGE: is_death=1 → {OVER,0}, highest priority. Otherwise:
  - W/D/S/A held → is_move=1, player_instr={MOV=5, dir, 0}, with dir UP=0, RIGHT=1, DOWN=2, LEFT=3.
  - Any other code → is_move=0, player_instr=0.
  - turn_left decrements each clock; at 1 → ACTION with cursor 0, turn_left=0, player_instr=0.
- ACTION: is_move=0.
  - D press: cursor+1 mod N_ACTIONS. A press: cursor−1 mod N_ACTIONS (0 wraps to N_ACTIONS−1).
  - J press: cursor 0 → ATTACK, start timeout counter; other cursors → DODGE with turn reload.
  - Other keys ignored.
- ATTACK:
  - atk_pass=1 → mon_dmg = min(mon_dmg+dmg_mon, 2^HP_W−1), computed at HP_W+1 bits then saturated. If result > MON_HP_MAX → {OVER,1}; else → DODGE with turn reload.
  - No atk_pass for ATK_TIMEOUT clocks → DODGE with turn reload, mon_dmg unchanged.
  - atk_pass on the timeout clock: atk_pass wins.
- OVER: SPACE press → {MENU,0}. mon_dmg is held for display.

## Timing
- All outputs are registered and change only on a clk rising edge. Response is one clock after the sampled input.
- Reset values: state={MENU,0}, player_instr=0, is_move=0, mon_dmg=0, turn_left=0, cursor=0, timeout=0, previous-key register=0.
- rst assertion mid-turn aborts immediately, asynchronously, to the reset values. First transition is possible on the first edge after deassertion.
- A key held across a page change does not produce a press in the new page.
- DODGE lasts exactly DODGE_CYCLES clocks from entry edge to ACTION edge, unless death occurs first.

## Structure
- `battle_pkg`: key codes, page codes, opcodes (HPY=1, DPY=2, IDG=3, SDG=4, MOV=5, SHP=6), direction codes, and the state-field widths.
- One sub-module, `key_edge`: registers keyboard and outputs a press strobe plus the press code. Instantiated once.

## Test plan
- Reset, then SPACE press → state 0x90, mon_dmg=0, turn_left=DODGE_CYCLES. Holding W → is_move=1, player_instr=0x5000.
- DODGE_CYCLES=8, no input → state reaches 0xB0 exactly 8 clocks after entering DODGE. is_death pulse on the 3rd clock → 0xC0 instead.
- ACTION, N_ACTIONS=4: A press → 0xB3; D press ×2 → 0xB1; J → 0x90. Holding D produces only one step.
- ATTACK with mon_dmg=90: atk_pass with dmg_mon=20 → mon_dmg=110, state 0xC1. With dmg_mon=5 → mon_dmg=95, state 0x90. With mon_dmg=250 and dmg_mon=20 → 255.
- ATTACK with ATK_TIMEOUT=5 and no atk_pass → 0x90 after 5 clocks, mon_dmg unchanged. atk_pass on the 5th clock is applied.
- rst asserted mid-DODGE between edges → outputs take reset values immediately. state=0xF0 forced → 0x10 next clock.
